// File: rtl/pcs_fifo_pkg.sv
// Shared defaults and helpers for the PCS TX single-clock FIFO.
package pcs_fifo_pkg;

  localparam int unsigned PCS_FIFO_DSIZE = 264;
  localparam int unsigned PCS_FIFO_ASIZE = 5;

  // Number of storage entries for a given address width.
  function automatic int unsigned fifo_depth(input int unsigned asize);
    return 32'd1 << asize;
  endfunction

endpackage

// File: rtl/pcs_fifo_ram.sv
// Storage array for pcs_sync_fifo: synchronous write, combinational or registered read.
module pcs_fifo_ram
  import pcs_fifo_pkg::*;
#(
  parameter int unsigned DSIZE = PCS_FIFO_DSIZE,
  parameter int unsigned ASIZE = PCS_FIFO_ASIZE,
  parameter bit          FWFT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             re,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int unsigned DEPTH = fifo_depth(ASIZE);

  logic [DSIZE-1:0] mem_q [DEPTH];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  generate
    if (FWFT) begin : g_comb_read
      // Head word is shown directly from the array.
      assign rdata = mem_q[raddr];
    end else begin : g_reg_read
      logic [DSIZE-1:0] rdata_q;
      logic [DSIZE-1:0] rdata_d;

      // Load the addressed word on an accepted read, otherwise hold.
      always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem_q[raddr];
      end

      // Output register, cleared on reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
      end

      assign rdata = rdata_q;
    end
  endgenerate

endmodule

// File: rtl/pcs_sync_fifo.sv
// Single-clock FIFO for the PCS TX datapath with level, thresholds,
// optional first-word-fall-through and sticky error flags.
module pcs_sync_fifo
  import pcs_fifo_pkg::*;
#(
  parameter int unsigned DSIZE    = PCS_FIFO_DSIZE,
  parameter int unsigned ASIZE    = PCS_FIFO_ASIZE,
  parameter int unsigned AF_LEVEL = 28,
  parameter int unsigned AE_LEVEL = 4,
  parameter bit          FWFT     = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rvalid,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   level,
  input  logic             clr_err,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PW   = ASIZE + 1;
  localparam logic [ASIZE:0] AF_L = PW'(AF_LEVEL);
  localparam logic [ASIZE:0] AE_L = PW'(AE_LEVEL);

  logic [ASIZE:0] wptr_q, wptr_d;
  logic [ASIZE:0] rptr_q, rptr_d;
  logic [ASIZE:0] level_q, level_d;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;
  logic           full_s, empty_s;
  logic           wr_acc, rd_acc;

  // Status decode from registered pointers/level and request qualification.
  always_comb begin
    empty_s = (wptr_q == rptr_q);
    full_s  = (wptr_q[ASIZE] != rptr_q[ASIZE]) &&
              (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]);
    wr_acc  = winc & ~full_s;
    rd_acc  = rinc & ~empty_s;
  end

  // Next pointers, occupancy and sticky errors (a new event beats clr_err).
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    level_d = level_q;
    if (wr_acc) wptr_d = wptr_q + PW'(1);
    if (rd_acc) rptr_d = rptr_q + PW'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + PW'(1);
      2'b01:   level_d = level_q - PW'(1);
      default: level_d = level_q;
    endcase
    overflow_d  = (winc & full_s)  | (overflow_q  & ~clr_err);
    underflow_d = (rinc & empty_s) | (underflow_q & ~clr_err);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  pcs_fifo_ram #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE),
    .FWFT  (FWFT)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wptr_q[ASIZE-1:0]),
    .wdata (wdata),
    .re    (rd_acc),
    .raddr (rptr_q[ASIZE-1:0]),
    .rdata (rdata)
  );

  generate
    if (FWFT) begin : g_fwft_valid
      assign rvalid = ~empty_s;
    end else begin : g_reg_valid
      logic rvalid_q, rvalid_d;

      // Valid for exactly the cycle after an accepted read.
      always_comb begin
        rvalid_d = rd_acc;
      end

      // Valid qualifier register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rvalid_q <= 1'b0;
        else        rvalid_q <= rvalid_d;
      end

      assign rvalid = rvalid_q;
    end
  endgenerate

  assign rempty        = empty_s;
  assign wfull         = full_s;
  assign walmost_full  = (level_q >= AF_L);
  assign ralmost_empty = (level_q <= AE_L);
  assign level         = level_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

  a_level_matches_ptrs: assert property (
    @(posedge clk) disable iff (!rst_n) level_q == (wptr_q - rptr_q)
  );

endmodule

// File: tb/tb_pcs_sync_fifo.sv
// Bench for pcs_sync_fifo: a registered-read and an FWFT instance share stimulus
// and are compared each cycle against a queue-based model.
module tb_pcs_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wdata = '0;
  logic       winc = 1'b0;
  logic       rinc = 1'b0;
  logic       clr_err = 1'b0;

  logic       wfull_a, walmost_full_a, rvalid_a, rempty_a, ralmost_empty_a, overflow_a, underflow_a;
  logic [7:0] rdata_a;
  logic [2:0] level_a;
  logic       wfull_b, walmost_full_b, rvalid_b, rempty_b, ralmost_empty_b, overflow_b, underflow_b;
  logic [7:0] rdata_b;
  logic [2:0] level_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pcs_sync_fifo #(.DSIZE(8), .ASIZE(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .wfull(wfull_a),
    .walmost_full(walmost_full_a), .rinc(rinc), .rdata(rdata_a), .rvalid(rvalid_a),
    .rempty(rempty_a), .ralmost_empty(ralmost_empty_a), .level(level_a),
    .clr_err(clr_err), .overflow(overflow_a), .underflow(underflow_a)
  );

  pcs_sync_fifo #(.DSIZE(8), .ASIZE(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .wfull(wfull_b),
    .walmost_full(walmost_full_b), .rinc(rinc), .rdata(rdata_b), .rvalid(rvalid_b),
    .rempty(rempty_b), .ralmost_empty(ralmost_empty_b), .level(level_b),
    .clr_err(clr_err), .overflow(overflow_b), .underflow(underflow_b)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  // Reference model: a 4-deep queue plus sticky flags and the registered read word.
  logic [7:0] mq[$];
  logic       m_ovf, m_udf, m_rvalid;
  logic [7:0] m_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    end else begin
      automatic bit full  = (mq.size() == 4);
      automatic bit empty = (mq.size() == 0);
      automatic bit set_o = winc && full;
      automatic bit set_u = rinc && empty;
      m_rvalid = 1'b0;
      if (rinc && !empty) begin
        m_rdata  = mq.pop_front();
        m_rvalid = 1'b1;
      end
      if (winc && !full) mq.push_back(wdata);
      m_ovf = set_o ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
      m_udf = set_u ? 1'b1 : (clr_err ? 1'b0 : m_udf);
    end
  end

  // Compare both instances against the model every cycle.
  always @(negedge clk) begin
    automatic int n = mq.size();
    chk("level_a", level_a, n);
    chk("level_b", level_b, n);
    chk("rempty_a", rempty_a, n == 0);
    chk("rempty_b", rempty_b, n == 0);
    chk("wfull_a", wfull_a, n == 4);
    chk("wfull_b", wfull_b, n == 4);
    chk("almost_full_a", walmost_full_a, n >= 3);
    chk("almost_empty_a", ralmost_empty_a, n <= 1);
    chk("almost_full_b", walmost_full_b, n >= 3);
    chk("almost_empty_b", ralmost_empty_b, n <= 1);
    chk("overflow_a", overflow_a, m_ovf);
    chk("underflow_a", underflow_a, m_udf);
    chk("overflow_b", overflow_b, m_ovf);
    chk("underflow_b", underflow_b, m_udf);
    chk("rvalid_a", rvalid_a, m_rvalid);
    chk("rdata_a", rdata_a, m_rdata);
    chk("rvalid_b", rvalid_b, n != 0);
    if (n != 0) chk("rdata_b", rdata_b, mq[0]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] d [4];
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;

    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    chk("rst_level", level_a, 0);
    chk("rst_rempty", rempty_a, 1);
    chk("rst_rdata", rdata_a, 0);
    chk("rst_rvalid", rvalid_a, 0);
    chk("rst_almost_empty", ralmost_empty_a, 1);
    tick();

    // Fill with four words, watching thresholds.
    for (int i = 0; i < 4; i++) begin
      winc = 1'b1; wdata = d[i];
      tick();
      chk("fill_level", level_a, i + 1);
      if (i == 1) chk("fill_ae_drop", ralmost_empty_a, 0);
      if (i == 2) begin
        chk("fill_af_at3", walmost_full_a, 1);
        chk("fill_notfull_at3", wfull_a, 0);
      end
    end
    chk("fill_full", wfull_a, 1);

    // Write into a full FIFO.
    wdata = 8'h55;
    tick();
    winc = 1'b0;
    chk("ovf_set", overflow_a, 1);
    chk("ovf_level", level_a, 4);

    // Drain in order with one-cycle read latency.
    for (int i = 0; i < 4; i++) begin
      rinc = 1'b1;
      tick();
      chk("drain_rvalid", rvalid_a, 1);
      chk("drain_rdata", rdata_a, d[i]);
    end
    rinc = 1'b0;
    tick();
    chk("drain_rvalid_low", rvalid_a, 0);
    chk("drain_empty", rempty_a, 1);
    chk("drain_hold", rdata_a, 8'h44);

    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    chk("udf_set", underflow_a, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_ovf", overflow_a, 0);
    chk("clr_udf", underflow_a, 0);

    // Fall-through visibility one cycle after the write.
    winc = 1'b1; wdata = 8'hA5;
    tick();
    winc = 1'b0;
    chk("fwft_rdata", rdata_b, 8'hA5);
    chk("fwft_rvalid", rvalid_b, 1);
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    chk("fwft_empty_after_pop", rempty_b, 1);
    chk("reg_rdata_a5", rdata_a, 8'hA5);

    // Half-full streaming across pointer wrap.
    winc = 1'b1; wdata = 8'h01; tick();
    wdata = 8'h02; tick();
    for (int i = 0; i < 10; i++) begin
      winc = 1'b1; rinc = 1'b1; wdata = 8'(3 + i);
      tick();
      chk("stream_level", level_a, 2);
      chk("stream_rdata", rdata_a, i + 1);
    end
    rinc = 1'b0;
    wdata = 8'h0D; tick();
    wdata = 8'h0E; tick();
    chk("refill_full", wfull_a, 1);

    // Clear coinciding with a new overflow: set wins.
    clr_err = 1'b1;
    tick();
    winc = 1'b0;
    chk("clr_vs_set", overflow_a, 1);
    tick();
    clr_err = 1'b0;
    chk("clr_alone", overflow_a, 0);

    // Mid-operation asynchronous reset at level 3 with a flag set.
    winc = 1'b1; tick(); winc = 1'b0;
    rinc = 1'b1; tick(); rinc = 1'b0;
    chk("pre_rst_level", level_a, 3);
    chk("pre_rst_ovf", overflow_a, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_level", level_a, 0);
    chk("arst_rempty", rempty_a, 1);
    chk("arst_wfull", wfull_a, 0);
    chk("arst_ovf", overflow_a, 0);
    chk("arst_udf", underflow_a, 0);
    chk("arst_af", walmost_full_a, 0);
    chk("arst_level_b", level_b, 0);
    tick();
    #2 rst_n = 1'b1;
    tick();

    // Randomised traffic with varying write/read bias.
    for (int seg = 0; seg < 40; seg++) begin
      automatic int unsigned pw = $urandom_range(20, 80);
      automatic int unsigned pr = $urandom_range(20, 80);
      for (int c = 0; c < 50; c++) begin
        winc    = ($urandom_range(99) < pw);
        rinc    = ($urandom_range(99) < pr);
        clr_err = ($urandom_range(15) == 0);
        wdata   = 8'($urandom);
        tick();
      end
    end
    winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
